game_step: RTL

- Next-state engine for the Arkanoid datapath. It sits directly upstream of the game-state register bank and produces the values that the bank samples every clock.
- On each frame tick it snapshots the current game state fed back from the register bank. It then computes paddle motion, ball motion, wall/paddle bounces, ball loss and brick collisions over several cycles, and commits the new state.
- Between commits its registered outputs hold the last committed state, so the register bank is stable.

---
 rtl/game_step.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_step.sv
// Per-frame next-state engine: a tick starts MOVE, WALL, SCAN x10, COMMIT, and the outputs update 13 clocks after the tick.
// No backpressure: a tick arriving while busy or after game over is dropped, and the outputs hold the last committed state.
module game_step #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BALL_R    = 4,
   parameter int BALL_STEP = 2,
   parameter int PAD_HALF  = 32,
   parameter int PAD_STEP  = 4,
   parameter int PAD_TOP   = 466,
   parameter int IX_NAV    = 320,
   parameter int IY_NAV    = 470,
   parameter int IX_PAL    = 320,
   parameter int IY_PAL    = 450,
   parameter int BRICK_W   = 64,
   parameter int BRICK_Y0  = 40,
   parameter int BRICK_H   = 16,
   parameter int VITE      = 3,
   parameter int BLOCCHI   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [9:0]  i_xpal,
   input  logic [9:0]  i_ypal,
   input  logic        i_xdirpal,
   input  logic        i_ydirpal,
   input  logic [9:0]  i_xnav,
   input  logic [9:0]  i_bri,
   input  logic [19:0] i_hits,
   input  logic [1:0]  i_life,
   input  logic [3:0]  i_brick,
   output logic [9:0]  o_xpal,
   output logic [9:0]  o_ypal,
   output logic [9:0]  o_xnav,
   output logic [9:0]  o_ynav,
   output logic        o_xdirpal,
   output logic        o_ydirpal,
   output logic [9:0]  o_bri,
   output logic [19:0] o_hits,
   output logic [1:0]  o_life,
   output logic [3:0]  o_brick,
   output logic        busy,
   output logic        done,
   output logic        game_over
);

   localparam logic signed [11:0] BR      = 12'(BALL_R);
   localparam logic signed [11:0] BSTEP   = 12'(BALL_STEP);
   localparam logic signed [11:0] PH      = 12'(PAD_HALF);
   localparam logic signed [11:0] PSTEP   = 12'(PAD_STEP);
   localparam logic signed [11:0] PT      = 12'(PAD_TOP);
   localparam logic signed [11:0] X_EDGE  = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_EDGE  = 12'(SCREEN_H - 1);
   localparam logic signed [11:0] NAV_MAX = 12'(SCREEN_W - 1 - PAD_HALF);
   localparam logic signed [11:0] BY0     = 12'(BRICK_Y0);
   localparam logic signed [11:0] BY1     = 12'(BRICK_Y0 + BRICK_H);
   localparam logic signed [11:0] XP0     = 12'(IX_PAL);
   localparam logic signed [11:0] YP0     = 12'(IY_PAL);
   localparam logic signed [11:0] XN0     = 12'(IX_NAV);
   // Bricks 0-3 take 3 hits, 4-6 take 2, 7-9 take 1; brick 0 sits in the LSBs.
   localparam logic [19:0] HITS0 = {2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

   typedef enum logic [2:0] {IDLE, MOVE, WALL, SCAN, COMMIT} state_t;

   state_t             state;
   logic signed [11:0] xw, yw, nav;
   logic               xdw, ydw;
   logic [9:0]         bri_w;
   logic [19:0]        hits_w;
   logic [1:0]         life_w;
   logic [3:0]         brick_w;
   logic [3:0]         idx;
   logic               hit_done;

   logic signed [11:0] mv_x, mv_y, mv_nav;
   logic signed [11:0] wx, wy, dx, adx;
   logic               wxd, wyd, lost;
   logic signed [11:0] lo, hi;
   logic [1:0]         old_h;
   logic               scan_hit;

   assign o_ynav    = 10'(IY_NAV);
   assign game_over = (o_life == 2'd0) || (o_brick == 4'd0);

   always_comb begin
      mv_x   = xdw ? xw - BSTEP : xw + BSTEP;
      mv_y   = ydw ? yw + BSTEP : yw - BSTEP;
      mv_nav = nav;
      if (btn_left && !btn_right)
         mv_nav = (nav - PSTEP < PH) ? PH : nav - PSTEP;
      else if (btn_right && !btn_left)
         mv_nav = (nav + PSTEP > NAV_MAX) ? NAV_MAX : nav + PSTEP;
   end

   // Wall checks are cumulative: each one sees the result of the previous.
   always_comb begin
      wx   = xw;
      wy   = yw;
      wxd  = xdw;
      wyd  = ydw;
      lost = 1'b0;
      if (wx - BR <= 12'sd0) begin
         wx  = BR;
         wxd = 1'b0;
      end
      if (wx + BR >= X_EDGE) begin
         wx  = X_EDGE - BR;
         wxd = 1'b1;
      end
      if (wy - BR <= 12'sd0) begin
         wy  = BR;
         wyd = 1'b1;
      end
      dx  = wx - nav;
      adx = (dx < 12'sd0) ? -dx : dx;
      if (wyd && (wy + BR >= PT) && (adx <= PH)) begin
         wy  = PT - BR;
         wyd = 1'b0;
         wxd = (wx < nav);
      end else if (wy + BR >= Y_EDGE) begin
         lost = 1'b1;
      end
   end

   always_comb begin
      lo       = 12'(int'(idx) * BRICK_W);
      hi       = lo + 12'(BRICK_W);
      old_h    = hits_w[{idx, 1'b0} +: 2];
      scan_hit = bri_w[idx] && !hit_done &&
                 (xw + BR >= lo) && (xw - BR < hi) &&
                 (yw + BR >= BY0) && (yw - BR < BY1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         o_xpal    <= 10'(IX_PAL);
         o_ypal    <= 10'(IY_PAL);
         o_xnav    <= 10'(IX_NAV);
         o_xdirpal <= 1'b0;
         o_ydirpal <= 1'b0;
         o_bri     <= '1;
         o_hits    <= HITS0;
         o_life    <= 2'(VITE);
         o_brick   <= 4'(BLOCCHI);
         busy      <= 1'b0;
         done      <= 1'b0;
         xw        <= XP0;
         yw        <= YP0;
         nav       <= XN0;
         xdw       <= 1'b0;
         ydw       <= 1'b0;
         bri_w     <= '1;
         hits_w    <= HITS0;
         life_w    <= 2'(VITE);
         brick_w   <= 4'(BLOCCHI);
         idx       <= '0;
         hit_done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_tick && !game_over) begin
                  xw      <= 12'(i_xpal);
                  yw      <= 12'(i_ypal);
                  nav     <= 12'(i_xnav);
                  xdw     <= i_xdirpal;
                  ydw     <= i_ydirpal;
                  bri_w   <= i_bri;
                  hits_w  <= i_hits;
                  life_w  <= i_life;
                  brick_w <= i_brick;
                  busy    <= 1'b1;
                  state   <= MOVE;
               end
            end
            MOVE: begin
               xw    <= mv_x;
               yw    <= mv_y;
               nav   <= mv_nav;
               state <= WALL;
            end
            WALL: begin
               if (lost) begin
                  life_w <= (life_w == 2'd0) ? 2'd0 : life_w - 2'd1;
                  xw     <= XP0;
                  yw     <= YP0;
                  xdw    <= 1'b0;
                  ydw    <= 1'b0;
                  nav    <= XN0;
                  state  <= COMMIT;
               end else begin
                  xw       <= wx;
                  yw       <= wy;
                  xdw      <= wxd;
                  ydw      <= wyd;
                  idx      <= '0;
                  hit_done <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (scan_hit) begin
                  hits_w[{idx, 1'b0} +: 2] <= (old_h <= 2'd1) ? 2'd0 : old_h - 2'd1;
                  ydw      <= ~ydw;
                  hit_done <= 1'b1;
                  if (old_h <= 2'd1) begin
                     bri_w[idx] <= 1'b0;
                     brick_w    <= (brick_w == 4'd0) ? 4'd0 : brick_w - 4'd1;
                  end
               end
               if (idx == 4'd9)
                  state <= COMMIT;
               else
                  idx <= idx + 4'd1;
            end
            COMMIT: begin
               o_xpal    <= xw[9:0];
               o_ypal    <= yw[9:0];
               o_xnav    <= nav[9:0];
               o_xdirpal <= xdw;
               o_ydirpal <= ydw;
               o_bri     <= bri_w;
               o_hits    <= hits_w;
               o_life    <= life_w;
               o_brick   <= brick_w;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
